nonce_result_scanner: RTL and testbench
=======================================

// Module: nonce_result_scanner
// PURPOSE
//  Downstream of bitcoin_hash. After it writes NUM_NONCES final-hash H0 words (one per nonce)
//  to memory, this block reads them back, compares each against a difficulty target, and
//  reports the golden nonce (lowest-index match), match count and minimum hash/nonce.
//  Writes a 4-word summary record to memory. Shares the memory port protocol of bitcoin_hash.
// PARAMETERS
//  NUM_NONCES  16  hash words to scan; nonce index = word offset 0..NUM_NONCES-1
//  CNT_W       $clog2(NUM_NONCES+1)  width of match_count
// PORTS
//  clk             in   1      clock
//  reset_n         in   1      reset, asynchronous, active-low
//  start           in   1      begin scan; sampled only in IDLE
//  result_addr     in   16     base address of the NUM_NONCES hash words
//  summary_addr    in   16     base address of the 4-word summary record
//  target          in   32     difficulty target, unsigned; latched at start
//  done            out  1      high when in IDLE (level)
//  mem_clk         out  1      = clk
//  mem_we          out  1      high only in WRITE
//  mem_addr        out  16     memory address
//  mem_write_data  out  32     memory write data
//  mem_read_data   in   32     memory read data, valid the cycle after the edge sampling mem_addr
//  found           out  1      at least one hash < target
//  golden_nonce    out  32     lowest index with hash < target; 0 if none
//  match_count     out  CNT_W  number of hashes < target
//  min_hash        out  32     smallest hash word scanned
//  min_nonce       out  32     index of min_hash (lowest index on ties)
// BEHAVIOUR
//  Reset: state IDLE; done=1, mem_we=0, mem_addr=0, mem_write_data=0, found=0, golden_nonce=0,
//   match_count=0, min_hash=32'hFFFFFFFF, min_nonce=0. Reset mid-scan aborts immediately;
//   no further writes are issued.
//  FSM: IDLE -> READ -> WRITE -> IDLE.
//  IDLE: on start at edge E0, latch result_addr, summary_addr and target.
//   Clear found, golden_nonce and match_count; step counter c=0; go to READ.
//   Results hold stable in IDLE until the next start. start while not IDLE is ignored.
//  READ: c runs 0..NUM_NONCES; mem_addr = result_addr+c for c<NUM_NONCES.
//   At each READ edge with c>=1, capture word k=c-1 (addressed during the previous cycle).
//   Compare rules for captured word k:
//   - match when hash < target (strict unsigned); match_count++.
//   - first match sets found=1 and golden_nonce=k; later matches do not change golden_nonce.
//   - k==0 loads min_hash/min_nonce unconditionally; for k>0 update only if hash < min_hash.
//   At c==NUM_NONCES (final capture), go to WRITE with w=0.
//  WRITE: mem_we=1; mem_addr = summary_addr+w for w=0..3. Word layout:
//   w=0 {found, 15'b0, 16'(match_count)}; w=1 golden_nonce; w=2 min_hash; w=3 min_nonce.
//   At w==3 edge go to IDLE.
//  Latency: done rises after edge E0+NUM_NONCES+5 (21 edges for default).
//   done is low from E0+1 through then.
//  Address arithmetic is 16-bit and wraps modulo 2^16; no error is flagged.
//  target=0: no match, found=0. target=FFFFFFFF: every word except FFFFFFFF matches.
// STRUCTURE
//  bitcoin_pkg: state enum {IDLE,READ,WRITE}, NUM_NONCES default, summary word offsets
//   (SUM_STATUS=0, SUM_GOLDEN=1, SUM_MIN_HASH=2, SUM_MIN_NONCE=3).
//  Sub-module nonce_min_tracker: clear/valid/word/index/target in;
//   found/golden/count/min regs out.
//   Holds all compare/update logic; the top level keeps the FSM and memory sequencing.
// TESTING
//  1. Words 0..15 = 32'h10000000+i, target=32'h10000003
//     -> found=1, golden=0, count=3, min_hash=32'h10000000, min_nonce=0.
//     Summary words = 32'h80000003, 0, 32'h10000000, 0.
//  2. All words 32'h50000000, word 9 = 32'h00000100, target=32'h00001000
//     -> found=1, golden=9, count=1, min_nonce=9.
//  3. All words 32'hFFFFFFFF, target=32'hFFFFFFFF -> found=0, golden=0, count=0,
//     min_hash=FFFFFFFF, min_nonce=0. Summary word0=0.
//  4. Words 4 and 11 both 32'h00000005 (minimum), target=0 -> found=0, min_nonce=4
//     (tie keeps lower index).
//  5. Cycle check: start pulse -> done low next cycle, exactly 4 mem_we cycles
//     at summary_addr..+3, done high 21 edges after start.
//     start re-asserted mid-scan is ignored.
//  6. reset_n low during READ c=7 -> next cycle done=1, mem_we=0, outputs at reset values.
//     A subsequent start completes normally.

Source files
------------

// File: rtl/nonce_result_scanner_pkg.sv
// Shared types and constants for the nonce result scanner: FSM states,
// default scan length and the layout of the summary record.
package nonce_result_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned NUM_NONCES_DEFAULT = 16;

  localparam logic [1:0] SUM_STATUS    = 2'd0;
  localparam logic [1:0] SUM_GOLDEN    = 2'd1;
  localparam logic [1:0] SUM_MIN_HASH  = 2'd2;
  localparam logic [1:0] SUM_MIN_NONCE = 2'd3;

  function automatic logic [31:0] status_word(input logic found, input logic [15:0] count);
    return {found, 15'b0, count};
  endfunction

endpackage

// File: rtl/nonce_result_scanner_if.sv
// Memory port shared with bitcoin_hash: synchronous read (data valid the
// cycle after the address is sampled), single write strobe.
interface nonce_result_scanner_if;

  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/nonce_min_tracker.sv
// Compare/accumulate stage: counts hashes below target, remembers the first
// matching index, and tracks the minimum hash with lowest-index tie-break.
module nonce_min_tracker #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [31:0]      word,
  input  logic [31:0]      index,
  input  logic [31:0]      target,
  output logic             found,
  output logic [31:0]      golden,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      min_hash,
  output logic [31:0]      min_index
);

  logic is_match;
  logic is_new_min;

  assign is_match   = word < target;
  // Index 0 seeds the minimum so a stale value from a previous scan never survives.
  assign is_new_min = (index == '0) || (word < min_hash);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found     <= 1'b0;
      golden    <= '0;
      count     <= '0;
      min_hash  <= '1;
      min_index <= '0;
    end else if (clear) begin
      found  <= 1'b0;
      golden <= '0;
      count  <= '0;
    end else if (valid) begin
      if (is_match) begin
        count <= count + CNT_W'(1);
        if (!found) begin
          found  <= 1'b1;
          golden <= index;
        end
      end
      if (is_new_min) begin
        min_hash  <= word;
        min_index <= index;
      end
    end
  end

endmodule

// File: rtl/nonce_result_scanner.sv
// Reads back NUM_NONCES final-hash words, scores them against a target and
// writes a 4-word summary record; FSM and memory sequencing live here.
module nonce_result_scanner
  import nonce_result_scanner_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int unsigned CNT_W      = $clog2(NUM_NONCES + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             result_addr,
  input  logic [15:0]             summary_addr,
  input  logic [31:0]             target,
  output logic                    done,
  nonce_result_scanner_if.master  mem,
  output logic                    found,
  output logic [31:0]             golden_nonce,
  output logic [CNT_W-1:0]        match_count,
  output logic [31:0]             min_hash,
  output logic [31:0]             min_nonce
);

  localparam int unsigned STEP_W = $clog2(NUM_NONCES + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_NONCES);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q;
  logic [1:0]        wr_q;
  logic [15:0]       result_base_q;
  logic [15:0]       summary_base_q;
  logic [31:0]       target_q;

  logic              trk_clear;
  logic              trk_valid;
  logic [31:0]       trk_index;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      step_q         <= '0;
      wr_q           <= '0;
      result_base_q  <= '0;
      summary_base_q <= '0;
      target_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            result_base_q  <= result_addr;
            summary_base_q <= summary_addr;
            target_q       <= target;
            step_q         <= '0;
          end
        end
        READ: begin
          step_q <= step_q + STEP_W'(1);
          if (step_q == LAST_STEP) wr_q <= '0;
        end
        WRITE: wr_q <= wr_q + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (step_q == LAST_STEP) state_d = WRITE;
      WRITE:   if (wr_q == SUM_MIN_NONCE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step c captures the word addressed during step c-1, so capture lags the address by one.
  assign trk_clear = (state_q == IDLE) && start;
  assign trk_valid = (state_q == READ) && (step_q != '0);
  assign trk_index = 32'(step_q - STEP_W'(1));

  nonce_min_tracker #(
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (trk_clear),
    .valid     (trk_valid),
    .word      (mem.mem_read_data),
    .index     (trk_index),
    .target    (target_q),
    .found     (found),
    .golden    (golden_nonce),
    .count     (match_count),
    .min_hash  (min_hash),
    .min_index (min_nonce)
  );

  assign mem.mem_clk = clk;
  assign done        = (state_q == IDLE);

  always_comb begin
    mem.mem_we         = 1'b0;
    mem.mem_addr       = '0;
    mem.mem_write_data = '0;
    case (state_q)
      READ: mem.mem_addr = result_base_q + 16'(step_q);
      WRITE: begin
        mem.mem_we   = 1'b1;
        mem.mem_addr = summary_base_q + 16'(wr_q);
        case (wr_q)
          SUM_STATUS:   mem.mem_write_data = status_word(found, 16'(match_count));
          SUM_GOLDEN:   mem.mem_write_data = golden_nonce;
          SUM_MIN_HASH: mem.mem_write_data = min_hash;
          default:      mem.mem_write_data = min_nonce;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Randomised and directed scans of nonce_result_scanner; summary writes are
// scoreboarded by a monitor, final results checked against a reference model.
module tb_nonce_result_scanner;

  localparam int unsigned NUM = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] result_addr;
  logic [15:0] summary_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [31:0] golden_nonce;
  logic [4:0]  match_count;
  logic [31:0] min_hash;
  logic [31:0] min_nonce;

  nonce_result_scanner_if mem_if ();

  nonce_result_scanner #(
    .NUM_NONCES (NUM)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .result_addr  (result_addr),
    .summary_addr (summary_addr),
    .target       (target),
    .done         (done),
    .mem          (mem_if),
    .found        (found),
    .golden_nonce (golden_nonce),
    .match_count  (match_count),
    .min_hash     (min_hash),
    .min_nonce    (min_nonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory image: summary writes are checked by the monitor, not stored.
  logic [31:0] mem_arr [0:65535];
  always @(posedge mem_if.mem_clk) mem_if.mem_read_data <= mem_arr[mem_if.mem_addr];

  logic [31:0] words [NUM];
  wr_t         exp_q [$];
  int unsigned checks;
  int unsigned errors;
  int unsigned wr_seen;

  logic        e_found;
  logic [31:0] e_golden;
  int unsigned e_cnt;
  logic [31:0] e_min;
  logic [31:0] e_mini;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: first index below target, number below target, smallest word at lowest index.
  function automatic void model(input logic [31:0] tgt);
    e_found  = 1'b0;
    e_golden = '0;
    e_cnt    = 0;
    e_min    = words[0];
    e_mini   = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (words[i] < tgt) begin
        e_cnt++;
        if (!e_found) begin
          e_found  = 1'b1;
          e_golden = i;
        end
      end
      if (words[i] < e_min) begin
        e_min  = words[i];
        e_mini = i;
      end
    end
  endfunction

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset_n && mem_if.mem_we) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, none expected",
                   mem_if.mem_addr, mem_if.mem_write_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_if.mem_addr), 32'(e.addr));
          chk("wr_data", mem_if.mem_write_data, e.data);
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_we"}, 32'(mem_if.mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_if.mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_if.mem_write_data, 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_golden"}, golden_nonce, 32'd0);
    chk({tag, "_count"}, 32'(match_count), 32'd0);
    chk({tag, "_min_hash"}, min_hash, 32'hFFFF_FFFF);
    chk({tag, "_min_nonce"}, min_nonce, 32'd0);
  endtask

  task automatic load_words(input logic [15:0] ra);
    for (int unsigned i = 0; i < NUM; i++) mem_arr[ra + 16'(i)] = words[i];
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_scan(input logic [15:0] ra, input logic [15:0] sa,
                          input logic [31:0] tgt, input bit mid_start);
    int unsigned n;
    int unsigned wr_base;
    bit          got;
    load_words(ra);
    model(tgt);
    exp_q.push_back('{addr: sa,          data: {e_found, 15'b0, 16'(e_cnt)}});
    exp_q.push_back('{addr: sa + 16'd1,  data: e_golden});
    exp_q.push_back('{addr: sa + 16'd2,  data: e_min});
    exp_q.push_back('{addr: sa + 16'd3,  data: e_mini});
    wr_base = wr_seen;
    chk("done_before_start", 32'(done), 32'd1);
    start        = 1'b1;
    result_addr  = ra;
    summary_addr = sa;
    target       = tgt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_low_after_start", 32'(done), 32'd0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      start = mid_start && (n == 6);
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
    end
    chk("done_latency", n, NUM + 5);
    chk("write_cycles", wr_seen - wr_base, 32'd4);
    chk("writes_left", exp_q.size(), 32'd0);
    exp_q.delete();
    chk("found", 32'(found), 32'(e_found));
    chk("golden_nonce", golden_nonce, e_golden);
    chk("match_count", 32'(match_count), e_cnt);
    chk("min_hash", min_hash, e_min);
    chk("min_nonce", min_nonce, e_mini);
  endtask

  initial begin
    logic [15:0] ra;
    logic [31:0] tgt;
    checks       = 0;
    errors       = 0;
    wr_seen      = 0;
    reset_n      = 1'b0;
    start        = 1'b0;
    result_addr  = '0;
    summary_addr = '0;
    target       = '0;
    for (int i = 0; i < 65536; i++) mem_arr[i] = '0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < NUM; i++) words[i] = 32'h1000_0000 + i;
    run_scan(16'h0100, 16'h0200, 32'h1000_0003, 1'b0);
    chk("t1_count", 32'(match_count), 32'd3);
    chk("t1_min_hash", min_hash, 32'h1000_0000);

    for (int unsigned i = 0; i < NUM; i++) words[i] = 32'h5000_0000;
    words[9] = 32'h0000_0100;
    run_scan(16'h0300, 16'h0400, 32'h0000_1000, 1'b0);
    chk("t2_golden", golden_nonce, 32'd9);

    for (int unsigned i = 0; i < NUM; i++) words[i] = 32'hFFFF_FFFF;
    run_scan(16'h0500, 16'h0600, 32'hFFFF_FFFF, 1'b0);

    for (int unsigned i = 0; i < NUM; i++) words[i] = 32'h7000_0000 + i;
    words[4]  = 32'h0000_0005;
    words[11] = 32'h0000_0005;
    run_scan(16'h0700, 16'h0800, 32'h0000_0000, 1'b0);
    chk("t4_min_nonce", min_nonce, 32'd4);

    // Mid-scan start is ignored; address ranges straddle the 16-bit wrap.
    for (int unsigned i = 0; i < NUM; i++) words[i] = 32'h1000_0000 + i;
    run_scan(16'hFFF8, 16'hFFFE, 32'h1000_0003, 1'b1);

    // Reset while READ is at step 7.
    for (int unsigned i = 0; i < NUM; i++) words[i] = 32'($urandom_range(0, 1000));
    load_words(16'h0900);
    start        = 1'b1;
    result_addr  = 16'h0900;
    summary_addr = 16'h0A00;
    target       = 32'h0000_0200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midrst");
    reset_n = 1'b1;
    @(negedge clk);
    run_scan(16'h0900, 16'h0A00, 32'h0000_0200, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int unsigned i = 0; i < NUM; i++)
        words[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 3))
        0:       tgt = '0;
        1:       tgt = '1;
        2:       tgt = 32'($urandom_range(0, 40));
        default: tgt = $urandom;
      endcase
      ra = 16'($urandom);
      run_scan(ra, ra + 16'h0040, tgt, (t % 2) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
